// File: rtl/control_pipe_unit_pkg.sv
// Shared decode constants, ALU operation codes and the ID/EX control word
// for the pipelined MIPS control unit.
package control_pkg;

  localparam int ALU_W = 5;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_SPECIAL3 = 6'h1F;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_MOVN  = 6'h0B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_MSUB  = 6'h04;
  localparam logic [5:0] FN_BSHFL = 6'h20;
  localparam logic [4:0] SA_SEB   = 5'h10;
  localparam logic [4:0] SA_SEH   = 5'h18;
  localparam logic [4:0] RT_BGEZ  = 5'h01;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND   = 5'd2,  ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT   = 5'd6,  ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA   = 5'd10, ALU_ROTR = 5'd11,
    ALU_SEB  = 5'd12, ALU_SEH  = 5'd13, ALU_MOVN  = 5'd14, ALU_MOVZ = 5'd15,
    ALU_MUL  = 5'd16, ALU_MULT = 5'd17, ALU_MULTU = 5'd18, ALU_MADD = 5'd19,
    ALU_MSUB = 5'd20, ALU_MTHI = 5'd21, ALU_MTLO  = 5'd22, ALU_MFHI = 5'd23,
    ALU_MFLO = 5'd24, ALU_BEQ  = 5'd25, ALU_BNE   = 5'd26, ALU_BGEZ = 5'd27,
    ALU_LUI  = 5'd28, ALU_BGTZ = 5'd29, ALU_BLEZ  = 5'd30, ALU_JUMP = 5'd31
  } alu_op_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} busy_state_t;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    input_a_mux;
    logic    input_b_mux;
    logic    sign_extend;
    alu_op_t alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t BUBBLE = '0;

  // Register-destination ALU instruction; shamt_sel routes the shift amount to input A.
  function automatic ctrl_word_t r_word(input alu_op_t op, input logic shamt_sel);
    ctrl_word_t w;
    w = BUBBLE;
    w.reg_write   = 1'b1;
    w.reg_dst     = 1'b1;
    w.mem_to_reg  = 1'b1;
    w.input_a_mux = shamt_sel;
    w.alu_op      = op;
    return w;
  endfunction

  function automatic ctrl_word_t i_word(input alu_op_t op, input logic zext);
    ctrl_word_t w;
    w = BUBBLE;
    w.reg_write   = 1'b1;
    w.mem_to_reg  = 1'b1;
    w.input_b_mux = 1'b1;
    w.sign_extend = zext;
    w.alu_op      = op;
    return w;
  endfunction

  function automatic ctrl_word_t mem_word(input logic load);
    ctrl_word_t w;
    w = BUBBLE;
    w.reg_write   = load;
    w.mem_read    = load;
    w.mem_write   = ~load;
    w.input_b_mux = 1'b1;
    w.alu_op      = ALU_ADD;
    return w;
  endfunction

  // Non-writing word: HI/LO traffic and control transfers.
  function automatic ctrl_word_t ctl_word(input alu_op_t op, input logic branch);
    ctrl_word_t w;
    w = BUBBLE;
    w.branch = branch;
    w.alu_op = op;
    return w;
  endfunction

endpackage

// File: rtl/control_pipe_unit_if.sv
// ID-stage instruction inputs and ID/EX control outputs of the control unit.
interface control_pipe_unit_if #(parameter int ALUOP_W = 5);
  logic [31:0]        Instruction;
  logic               InstrValid;
  logic               BranchTaken;
  logic               RegWrite, RegDst, MemRead, MemWrite, MemToReg, Branch;
  logic               InputA_MuxSignal, InputB_MuxSignal, signExtendSignal;
  logic [ALUOP_W-1:0] ALUInstruction;
  logic               ExValid, Stall, HiLoBusy, IllegalInstr;

  modport master (
    output Instruction, InstrValid, BranchTaken,
    input  RegWrite, RegDst, MemRead, MemWrite, MemToReg, Branch,
    input  InputA_MuxSignal, InputB_MuxSignal, signExtendSignal,
    input  ALUInstruction, ExValid, Stall, HiLoBusy, IllegalInstr
  );

  modport slave (
    input  Instruction, InstrValid, BranchTaken,
    output RegWrite, RegDst, MemRead, MemWrite, MemToReg, Branch,
    output InputA_MuxSignal, InputB_MuxSignal, signExtendSignal,
    output ALUInstruction, ExValid, Stall, HiLoBusy, IllegalInstr
  );
endinterface

// File: rtl/control_pipe_unit_decode.sv
// Purely combinational MIPS decoder: control word plus the hazard-relevant
// attributes (reads rt, touches HI/LO, starts a multi-cycle multiply).
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_word_t  word,
  output logic        illegal,
  output logic        reads_rt,
  output logic        is_hilo,
  output logic        starts_mul
);

  logic [5:0] op_s, funct_s;
  logic [4:0] rt_s, sa_s;
  logic       unused_bits_s;

  assign op_s          = instr[31:26];
  assign funct_s       = instr[5:0];
  assign rt_s          = instr[20:16];
  assign sa_s          = instr[10:6];
  assign unused_bits_s = ^{instr[25:22], instr[15:11]};

  // Opcode/funct decode; anything unmatched yields a bubble flagged illegal.
  always_comb begin
    word       = BUBBLE;
    illegal    = 1'b0;
    reads_rt   = 1'b0;
    is_hilo    = 1'b0;
    starts_mul = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        reads_rt = 1'b1;
        case (funct_s)
          FN_SLL:  word = r_word(ALU_SLL, 1'b1);
          FN_SRL:  word = r_word(instr[21] ? ALU_ROTR : ALU_SRL, 1'b1);
          FN_SRA:  word = r_word(ALU_SRA, 1'b1);
          FN_SLLV: word = r_word(ALU_SLL, 1'b0);
          FN_SRLV: word = r_word(instr[6] ? ALU_ROTR : ALU_SRL, 1'b0);
          FN_SRAV: word = r_word(ALU_SRA, 1'b0);
          FN_JR:   begin word = ctl_word(ALU_JUMP, 1'b1); reads_rt = 1'b0; end
          FN_MOVZ: word = r_word(ALU_MOVZ, 1'b0);
          FN_MOVN: word = r_word(ALU_MOVN, 1'b0);
          FN_MFHI: begin word = r_word(ALU_MFHI, 1'b0); reads_rt = 1'b0; is_hilo = 1'b1; end
          FN_MFLO: begin word = r_word(ALU_MFLO, 1'b0); reads_rt = 1'b0; is_hilo = 1'b1; end
          FN_MTHI: begin word = ctl_word(ALU_MTHI, 1'b0); reads_rt = 1'b0; is_hilo = 1'b1; end
          FN_MTLO: begin word = ctl_word(ALU_MTLO, 1'b0); reads_rt = 1'b0; is_hilo = 1'b1; end
          FN_MULT:  begin word = ctl_word(ALU_MULT, 1'b0); is_hilo = 1'b1; starts_mul = 1'b1; end
          FN_MULTU: begin word = ctl_word(ALU_MULTU, 1'b0); is_hilo = 1'b1; starts_mul = 1'b1; end
          FN_ADD, FN_ADDU: word = r_word(ALU_ADD, 1'b0);
          FN_SUB, FN_SUBU: word = r_word(ALU_SUB, 1'b0);
          FN_AND:  word = r_word(ALU_AND, 1'b0);
          FN_OR:   word = r_word(ALU_OR, 1'b0);
          FN_XOR:  word = r_word(ALU_XOR, 1'b0);
          FN_NOR:  word = r_word(ALU_NOR, 1'b0);
          FN_SLT:  word = r_word(ALU_SLT, 1'b0);
          FN_SLTU: word = r_word(ALU_SLTU, 1'b0);
          default: begin illegal = 1'b1; reads_rt = 1'b0; end
        endcase
      end
      OP_SPECIAL2: begin
        reads_rt = 1'b1;
        case (funct_s)
          FN_MADD: begin word = ctl_word(ALU_MADD, 1'b0); is_hilo = 1'b1; starts_mul = 1'b1; end
          FN_MSUB: begin word = ctl_word(ALU_MSUB, 1'b0); is_hilo = 1'b1; starts_mul = 1'b1; end
          FN_MUL:  word = r_word(ALU_MUL, 1'b0);
          default: begin illegal = 1'b1; reads_rt = 1'b0; end
        endcase
      end
      OP_SPECIAL3: begin
        if (funct_s == FN_BSHFL && sa_s == SA_SEB) begin
          word = r_word(ALU_SEB, 1'b0); reads_rt = 1'b1;
        end else if (funct_s == FN_BSHFL && sa_s == SA_SEH) begin
          word = r_word(ALU_SEH, 1'b0); reads_rt = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_REGIMM: begin
        if (rt_s == RT_BGEZ) word = ctl_word(ALU_BGEZ, 1'b1);
        else illegal = 1'b1;
      end
      OP_J:   word = ctl_word(ALU_JUMP, 1'b1);
      OP_JAL: begin
        word = ctl_word(ALU_JUMP, 1'b1);
        word.reg_write  = 1'b1;
        word.mem_to_reg = 1'b1;
      end
      OP_BEQ:  begin word = ctl_word(ALU_BEQ, 1'b1); reads_rt = 1'b1; end
      OP_BNE:  begin word = ctl_word(ALU_BNE, 1'b1); reads_rt = 1'b1; end
      OP_BLEZ: word = ctl_word(ALU_BLEZ, 1'b1);
      OP_BGTZ: word = ctl_word(ALU_BGTZ, 1'b1);
      OP_ADDI, OP_ADDIU: word = i_word(ALU_ADD, 1'b0);
      OP_SLTI:  word = i_word(ALU_SLT, 1'b0);
      OP_SLTIU: word = i_word(ALU_SLTU, 1'b0);
      OP_ANDI:  word = i_word(ALU_AND, 1'b1);
      OP_ORI:   word = i_word(ALU_OR, 1'b1);
      OP_XORI:  word = i_word(ALU_XOR, 1'b1);
      OP_LUI:   word = i_word(ALU_LUI, 1'b0);
      OP_LB, OP_LH, OP_LW: word = mem_word(1'b1);
      OP_SB, OP_SH, OP_SW: begin word = mem_word(1'b0); reads_rt = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe_unit.sv
// Pipelined control unit: ID/EX control register, load-use and HI/LO hazard
// detection, and the HI/LO busy counter.
module control_pipe_unit #(
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 4
) (
  input logic               Clk,
  input logic               Reset,
  control_pipe_unit_if.slave bus
);
  import control_pkg::*;

  localparam int CNT_W       = $clog2(MUL_LAT + 1);
  localparam bit MULTI_CYCLE = (MUL_LAT > 1);

  ctrl_word_t        dec_word_s, ex_word_r;
  logic              dec_illegal_s, dec_reads_rt_s, dec_is_hilo_s, dec_starts_mul_s;
  logic              ex_valid_r, illegal_r;
  logic [4:0]        ex_rt_r, id_rs_s, id_rt_s;
  busy_state_t       state_r, state_n_s;
  logic [CNT_W-1:0]  cnt_r, cnt_n_s;
  logic              busy_s, load_use_s, hilo_hazard_s, stall_s, issue_s, accept_s;

  control_decode u_decode (
    .instr      (bus.Instruction),
    .word       (dec_word_s),
    .illegal    (dec_illegal_s),
    .reads_rt   (dec_reads_rt_s),
    .is_hilo    (dec_is_hilo_s),
    .starts_mul (dec_starts_mul_s)
  );

  assign id_rs_s       = bus.Instruction[25:21];
  assign id_rt_s       = bus.Instruction[20:16];
  assign busy_s        = (cnt_r != '0);
  assign load_use_s    = ex_word_r.mem_read & ex_valid_r & (ex_rt_r != 5'd0) &
                         ((ex_rt_r == id_rs_s) | (dec_reads_rt_s & (ex_rt_r == id_rt_s)));
  assign hilo_hazard_s = busy_s & dec_is_hilo_s;
  assign stall_s       = bus.InstrValid & (load_use_s | hilo_hazard_s) & ~bus.BranchTaken;
  assign issue_s       = bus.InstrValid & ~bus.BranchTaken & ~stall_s;
  assign accept_s      = issue_s & ~dec_illegal_s;

  // ID/EX register: reset, flush, stall, empty slot and illegal all load the bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_word_r  <= BUBBLE;
      ex_valid_r <= 1'b0;
      ex_rt_r    <= 5'd0;
      illegal_r  <= 1'b0;
    end else if (accept_s) begin
      ex_word_r  <= dec_word_s;
      ex_valid_r <= 1'b1;
      ex_rt_r    <= id_rt_s;
      illegal_r  <= 1'b0;
    end else begin
      ex_word_r  <= BUBBLE;
      ex_valid_r <= 1'b0;
      ex_rt_r    <= 5'd0;
      illegal_r  <= issue_s & dec_illegal_s;
    end
  end

  // HI/LO busy state and countdown register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Busy next-state: a flush never cancels a multiply already latched into ID/EX.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && dec_starts_mul_s && MULTI_CYCLE) begin
          state_n_s = ST_BUSY;
          cnt_n_s   = CNT_W'(MUL_LAT - 1);
        end else begin
          cnt_n_s   = '0;
        end
      end
      ST_BUSY: begin
        cnt_n_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) state_n_s = ST_IDLE;
        else state_n_s = ST_BUSY;
      end
      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = '0;
      end
    endcase
  end

  assign bus.RegWrite         = ex_word_r.reg_write;
  assign bus.RegDst           = ex_word_r.reg_dst;
  assign bus.MemRead          = ex_word_r.mem_read;
  assign bus.MemWrite         = ex_word_r.mem_write;
  assign bus.MemToReg         = ex_word_r.mem_to_reg;
  assign bus.Branch           = ex_word_r.branch;
  assign bus.InputA_MuxSignal = ex_word_r.input_a_mux;
  assign bus.InputB_MuxSignal = ex_word_r.input_b_mux;
  assign bus.signExtendSignal = ex_word_r.sign_extend;
  assign bus.ALUInstruction   = ALUOP_W'(ex_word_r.alu_op);
  assign bus.ExValid          = ex_valid_r;
  assign bus.IllegalInstr     = illegal_r;
  assign bus.HiLoBusy         = busy_s;
  assign bus.Stall            = stall_s;

endmodule

// File: doc/control_pipe_unit.md
# control_pipe_unit

Pipelined MIPS control unit that sits between the IF/ID register and the EX stage. It decodes the ID-stage instruction into the datapath control word and registers that word as the ID/EX control stage. It also detects load-use and HI/LO multi-cycle hazards, and generates stalls, bubbles and branch flushes. It replaces the purely combinational decoder wherever the datapath runs pipelined.

## Interface
- ALUOP_W, 5, width of ALUInstruction; ALU operation codes are fixed in the shared package.
- MUL_LAT, 4, total cycles (≥1) that a MULT/MULTU/MADD/MSUB occupies HI/LO.
- Clk  input  1  rising-edge clock; the block uses this single clock.
- Reset  input  1  synchronous, active-high reset.
- Instruction  input  32  instruction in ID (from IF/ID).
- InstrValid  input  1  Instruction is a real instruction, not a bubble.
- BranchTaken  input  1  EX resolved a taken branch or jump; flush ID.
- RegWrite, RegDst, MemRead, MemWrite, MemToReg, Branch, InputA_MuxSignal, InputB_MuxSignal, signExtendSignal  output  1 each  registered ID/EX control.
- ALUInstruction  output  ALUOP_W  registered ALU operation.
- ExValid  output  1  the ID/EX control word is a real instruction.
- Stall  output  1  combinational; hold PC and IF/ID this cycle.
- HiLoBusy  output  1  a HI/LO operation is still in flight.
- IllegalInstr  output  1  registered one-cycle pulse: an unknown encoding reached ID/EX.

## Operation
- Decode is combinational on Instruction. It covers R/I arithmetic, logical, shift/rotate, SEB/SEH, SLT family, MOVN/MOVZ, MUL/MULT(U)/MADD/MSUB, MFHI/MFLO/MTHI/MTLO, LW/LH/LB/SW/SH/SB/LUI, BEQ/BNE/BGEZ/BGTZ/BLEZ/J/JR/JAL.
- MemToReg=1 selects the ALU result and 0 selects memory.
- Every decoded instruction drives every control output; nothing holds its previous value.
- R-type writes use RegDst=1. This includes ADDU.
- Loads:
  - Control: RegWrite=1, MemRead=1, MemToReg=0, InputB_MuxSignal=1, ALU ADD.
  - Only LW/LH/LB set MemRead.
- Stores: RegWrite=0, MemWrite=1, InputB_MuxSignal=1, ALU ADD.
- LUI: RegWrite=1, MemRead=0, ALU code LUI.
- ANDI/ORI/XORI: signExtendSignal=1 (zero-extend). All other instructions: signExtendSignal=0.
- Bubble word: all control outputs 0, ALUInstruction=0, ExValid=0.
- Load-use hazard, all of the following true:
  - registered MemRead=1 and ExValid=1;
  - registered rt is nonzero;
  - registered rt equals ID rs, or equals ID rt for an instruction that reads rt.
- HI/LO hazard: HiLoBusy=1 and the ID instruction is MULT/MULTU/MADD/MSUB/MFHI/MFLO/MTHI/MTLO.
- Stall = InstrValid & (load-use | HI/LO hazard) & ~BranchTaken.
- Illegal: InstrValid=1 and no encoding matches. ID/EX takes a bubble and IllegalInstr=1.
- Busy state machine:
  - States: IDLE (counter=0) and BUSY (counter≠0).
  - IDLE→BUSY when a MULT/MULTU/MADD/MSUB is latched into ID/EX and MUL_LAT>1; counter loads MUL_LAT-1.
  - In BUSY the counter decrements every cycle. BUSY→IDLE when it reaches 0.
  - HiLoBusy = (counter≠0).

## Timing
- ID/EX update priority at each rising Clk:
  1. Reset: bubble, counter=0, IllegalInstr=0.
  2. BranchTaken: bubble.
  3. Stall: bubble.
  4. InstrValid=0: bubble.
  5. Otherwise: the decoded word.
- Reset values: all registered outputs 0 and ExValid=0. HiLoBusy and Stall are 0 because both are derived from reset state.
- Decode-to-output latency is 1 cycle.
- Load-use stall lasts exactly 1 cycle. The next cycle's registered MemRead is 0 because of the bubble.
- HI/LO stall:
  - Ends on the cycle HiLoBusy falls.
  - A dependent instruction entering ID right after a HI/LO op sees Stall for MUL_LAT-1 cycles.
- BranchTaken:
  - Overrides Stall in the same cycle.
  - Does not reset the counter; an issued HI/LO op always completes.
- Reset mid-BUSY clears the counter immediately.
- Back-to-back HI/LO ops never overlap because the second one stalls.
- Counter width: $clog2(MUL_LAT+1). The counter never wraps.

## Structure
- Shared package `control_pkg` holds:
  - opcode and funct localparams;
  - ALU operation codes (ADD 00000 … MFLO 11000, LUI 11100);
  - the control-word struct and the BUBBLE constant.
- Sub-module `control_decode`: purely combinational Instruction→control word + illegal + reads_rt + is_hilo.
- The top level holds the ID/EX register, hazard logic and busy counter.

## Test plan
- Hold Reset for 2 cycles → all outputs 0, Stall=0, HiLoBusy=0.
- ADD $3,$1,$2 (0x00221820) → next cycle RegWrite=1, RegDst=1, MemToReg=1, ALUInstruction=00000, ExValid=1.
- LW $2,0($1) (0x8C220000) then ADD $3,$2,$4 (0x00441820):
  - Stall=1 for one cycle, with a bubble in ID/EX;
  - ADD issues the following cycle.
- MUL_LAT=4; MULT $1,$2 (0x00220018) then MFLO $3 (0x00001812):
  - Stall=1 for 3 cycles;
  - MFLO then issues with ALUInstruction=11000.
- The load-use case above with BranchTaken=1 in the stall cycle → Stall=0 and a bubble is latched.
- Instruction 0xFC000000 with InstrValid=1 → IllegalInstr=1 for one cycle, ExValid=0.
